// File: rtl/layer_compositor.sv
// layer_compositor: two-stage pixel compositor for the VGA game path.
// S0 computes the scrolled background address and captures the layer inputs.
// S1 mixes the sprite layers over the background RAM data by fixed index
// priority, then registers sync-aligned RGB. A per-frame collision report
// between the player (layer 0) and every other layer is produced alongside.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 11,
  parameter int SCROLL_W   = 10,
  parameter int BG_SHIFT   = 2,
  parameter int BG_COL_W   = 8,
  parameter int BG_ROW_W   = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [COL_W-1:0]                  display_col,
  input  logic [ROW_W-1:0]                  display_row,
  input  logic                              visible,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic [NUM_LAYERS-1:0]             layer_visible,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]             layer_enable,
  input  logic [SCROLL_W-1:0]               scroll_speed,
  input  logic                              scroll_pause,
  output logic [BG_COL_W+BG_ROW_W-1:0]      bg_addr,
  input  logic [3*COLOR_W-1:0]              bg_q,
  output logic [COLOR_W-1:0]                red,
  output logic [COLOR_W-1:0]                green,
  output logic [COLOR_W-1:0]                blue,
  output logic                              hsync,
  output logic                              vsync,
  output logic [NUM_LAYERS-1:0]             collision_flags,
  output logic                              collision_valid
);

  localparam int PIX_W = 3 * COLOR_W;

  // ---------------------------------------------------------------------------
  // Stage 0: background address and frame start detection
  // ---------------------------------------------------------------------------
  logic [SCROLL_W-1:0]  scroll_offset;
  logic [COL_W-1:0]     bg_x;
  logic [BG_COL_W-1:0]  col_idx;
  logic [BG_ROW_W-1:0]  row_idx;
  logic                 frame_start_s0;

  // Carry out of the column addition is dropped: the background wraps
  // horizontally at the COL_W boundary.
  assign bg_x           = display_col + COL_W'(scroll_offset);
  assign col_idx        = bg_x[BG_SHIFT +: BG_COL_W];
  assign row_idx        = display_row[BG_SHIFT +: BG_ROW_W];
  assign frame_start_s0 = (display_col == '0) && (display_row == '0);

  // Sub-tile and out-of-range address bits are intentionally not used.
  logic unused_bits;
  assign unused_bits = ^{bg_x, display_row};

  // Scroll offset advances once per frame; pixel (0,0) itself still sees the
  // old offset because the address above is formed from the current value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scroll_offset <= '0;
    end else if (frame_start_s0 && !scroll_pause) begin
      // NOTE: non-blocking for all sequential state so every register samples
      // pre-edge values regardless of block ordering.
      scroll_offset <= scroll_offset + scroll_speed;
    end
  end

  // ---------------------------------------------------------------------------
  // S0 -> S1 pipeline registers, aligned with the one-cycle RAM read
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0]       visible_s1;
  logic [NUM_LAYERS*PIX_W-1:0] rgb_s1;
  logic [NUM_LAYERS-1:0]       enable_s1;
  logic                        active_s1;
  logic                        hsync_s1;
  logic                        vsync_s1;
  logic                        frame_start_s1;

  // Capture the RAM address and delay the layer/sync inputs to meet bg_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bg_addr        <= '0;
      visible_s1     <= '0;
      rgb_s1         <= '0;
      enable_s1      <= '0;
      active_s1      <= 1'b0;
      hsync_s1       <= 1'b0;
      vsync_s1       <= 1'b0;
      frame_start_s1 <= 1'b0;
    end else begin
      bg_addr        <= {col_idx, row_idx};
      visible_s1     <= layer_visible;
      rgb_s1         <= layer_rgb;
      enable_s1      <= layer_enable;
      active_s1      <= visible;
      hsync_s1       <= hsync_in;
      vsync_s1       <= vsync_in;
      frame_start_s1 <= frame_start_s0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: priority mix and collision detection
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] qual_s1;
  logic [PIX_W-1:0]      mix_rgb;
  logic [NUM_LAYERS-1:0] hits;

  assign qual_s1 = visible_s1 & enable_s1;

  // Lowest qualifying index wins; background fills in, blanking forces black.
  always_comb begin
    // NOTE: default assignment first so no path leaves mix_rgb unassigned,
    // which would otherwise infer a latch.
    mix_rgb = bg_q;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (qual_s1[i]) mix_rgb = rgb_s1[i*PIX_W +: PIX_W];
    end
    if (!active_s1) mix_rgb = '0;
  end

  // Player overlap with each other drawable layer on the current pixel.
  always_comb begin
    hits = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      hits[i] = active_s1 & qual_s1[0] & qual_s1[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------

  // Register colour and syncs together so they stay exactly aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      red   <= mix_rgb[0         +: COLOR_W];
      green <= mix_rgb[COLOR_W   +: COLOR_W];
      blue  <= mix_rgb[2*COLOR_W +: COLOR_W];
      hsync <= hsync_s1;
      vsync <= vsync_s1;
    end
  end

  logic [NUM_LAYERS-1:0] acc;

  // Accumulate hits across a frame; publish and restart at each frame start,
  // with the (0,0) pixel's own hits seeding the new frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc             <= '0;
      collision_flags <= '0;
      collision_valid <= 1'b0;
    end else if (frame_start_s1) begin
      collision_flags <= acc;
      acc             <= hits;
      collision_valid <= 1'b1;
    end else begin
      acc             <= acc | hits;
      collision_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed self-checking bench for layer_compositor: reset state, background
// address/data path, layer priority and enable, blanking, sync latency,
// scroll accumulation/pause/wrap, collision reporting and mid-frame reset.
module tb_layer_compositor;

  localparam int NUM_LAYERS = 4;
  localparam int COLOR_W    = 4;
  localparam int COL_W      = 12;
  localparam int ROW_W      = 11;
  localparam int SCROLL_W   = 10;

  logic                            clock;
  logic                            reset;
  logic [COL_W-1:0]                display_col;
  logic [ROW_W-1:0]                display_row;
  logic                            visible;
  logic                            hsync_in;
  logic                            vsync_in;
  logic [NUM_LAYERS-1:0]           layer_visible;
  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]           layer_enable;
  logic [SCROLL_W-1:0]             scroll_speed;
  logic                            scroll_pause;
  logic [15:0]                     bg_addr;
  logic [3*COLOR_W-1:0]            bg_q;
  logic [COLOR_W-1:0]              red;
  logic [COLOR_W-1:0]              green;
  logic [COLOR_W-1:0]              blue;
  logic                            hsync;
  logic                            vsync;
  logic [NUM_LAYERS-1:0]           collision_flags;
  logic                            collision_valid;

  int check_count = 0;
  int pass_count  = 0;

  layer_compositor dut (
    .clock           (clock),
    .reset           (reset),
    .display_col     (display_col),
    .display_row     (display_row),
    .visible         (visible),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .layer_visible   (layer_visible),
    .layer_rgb       (layer_rgb),
    .layer_enable    (layer_enable),
    .scroll_speed    (scroll_speed),
    .scroll_pause    (scroll_pause),
    .bg_addr         (bg_addr),
    .bg_q            (bg_q),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .hsync           (hsync),
    .vsync           (vsync),
    .collision_flags (collision_flags),
    .collision_valid (collision_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one active pixel with the given layer hits, then clock it into S1.
  task automatic pix(input int col, input int row, input logic [3:0] lvis);
    display_col   = COL_W'(col);
    display_row   = ROW_W'(row);
    visible       = 1'b1;
    layer_visible = lvis;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    display_col   = '0;
    display_row   = 11'd4;
    visible       = 1'b0;
    hsync_in      = 1'b0;
    vsync_in      = 1'b0;
    layer_visible = '0;
    // {rgb3, rgb2, rgb1, rgb0}: layer 0 pure red, layer 2 pure blue
    layer_rgb     = {12'h0F0, 12'hF00, 12'h0F0, 12'h00F};
    layer_enable  = 4'hF;
    scroll_speed  = '0;
    scroll_pause  = 1'b0;
    bg_q          = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_rgb",   32'({red, green, blue}), 32'h0);
    check("rst_sync",  32'({hsync, vsync}), 32'h0);
    check("rst_coll",  32'({collision_flags, collision_valid}), 32'h0);
    check("rst_addr",  32'(bg_addr), 32'h0);

    // Background path: col 8 row 4, no layers, offset 0
    pix(8, 4, 4'b0000);
    check("bg_addr", 32'(bg_addr), 32'h0201);
    bg_q = 12'hA53;
    pix(9, 4, 4'b0000);
    check("bg_red",   32'(red),   32'h3);
    check("bg_green", 32'(green), 32'h5);
    check("bg_blue",  32'(blue),  32'hA);

    // Priority: layers 0 and 2 visible, all enabled -> layer 0 (red)
    pix(20, 4, 4'b0101);
    tick();
    check("prio_rgb", 32'({red, green, blue}), 32'hF00);
    // Player disabled -> layer 2 (blue)
    layer_enable = 4'b1110;
    pix(21, 4, 4'b0101);
    tick();
    check("prio_en_rgb", 32'({red, green, blue}), 32'h00F);
    layer_enable = 4'hF;

    // Blanking with layers asserted, and sync latency
    visible       = 1'b0;
    layer_visible = 4'hF;
    hsync_in      = 1'b1;
    vsync_in      = 1'b1;
    tick();
    check("hsync_1clk", 32'(hsync), 32'h0);
    tick();
    check("blank_rgb",  32'({red, green, blue}), 32'h0);
    check("sync_2clk",  32'({hsync, vsync}), 32'h3);
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // Collision reporting
    do_reset();
    pix(5, 3, 4'b0000);
    pix(6, 3, 4'b0000);
    check("coll_no_pulse", 32'(collision_valid), 32'h0);
    pix(0, 0, 4'b0000);              // frame N start
    pix(1, 0, 4'b1001);              // player overlaps layer 3
    check("coll_n_valid", 32'(collision_valid), 32'h1);
    check("coll_n_flags", 32'(collision_flags), 32'h0);
    pix(2, 0, 4'b0000);
    check("coll_single_pulse", 32'(collision_valid), 32'h0);
    pix(3, 0, 4'b0000);
    pix(0, 0, 4'b0000);              // frame N+1 start (clean frame)
    pix(1, 0, 4'b0000);
    check("coll_n1_valid", 32'(collision_valid), 32'h1);
    check("coll_n1_flags", 32'(collision_flags), 32'h8);
    pix(2, 0, 4'b0000);
    check("coll_n1_drop", 32'(collision_valid), 32'h0);
    pix(0, 0, 4'b0101);              // frame N+2 start, overlap on (0,0)
    pix(1, 0, 4'b0000);
    check("coll_n2_flags", 32'(collision_flags), 32'h0);
    pix(2, 0, 4'b0000);
    pix(0, 0, 4'b0000);              // frame N+3 start
    pix(1, 0, 4'b0000);
    check("coll_origin_flags", 32'(collision_flags), 32'h4);

    // Scroll: speed 8, three frames, then pause for two
    do_reset();
    scroll_speed = 10'd8;
    pix(0, 0, 4'b0000);
    check("scroll_old_offset", 32'(bg_addr), 32'h0000);
    pix(0, 4, 4'b0000);
    check("scroll_8", 32'(bg_addr), 32'h0201);
    pix(0, 0, 4'b0000);
    pix(0, 0, 4'b0000);
    pix(0, 4, 4'b0000);
    check("scroll_24", 32'(bg_addr), 32'h0601);
    scroll_pause = 1'b1;
    pix(0, 0, 4'b0000);
    pix(0, 0, 4'b0000);
    pix(0, 4, 4'b0000);
    check("scroll_pause", 32'(bg_addr), 32'h0601);
    scroll_pause = 1'b0;

    // Scroll wrap: 1020 + 8 -> 4, and column overflow discarded
    do_reset();
    scroll_speed = 10'd1020;
    pix(0, 0, 4'b0000);
    scroll_speed = 10'd8;
    pix(0, 4, 4'b0000);
    check("scroll_1020", 32'(bg_addr), 32'hFF01);
    pix(0, 0, 4'b0000);
    pix(0, 4, 4'b0000);
    check("scroll_wrap", 32'(bg_addr), 32'h0101);
    pix(4094, 4, 4'b0000);
    check("col_overflow", 32'(bg_addr), 32'h0001);
    scroll_speed = '0;

    // Reset mid-frame
    pix(20, 4, 4'b0001);
    pix(21, 4, 4'b0001);
    check("pre_reset_rgb", 32'({red, green, blue}), 32'hF00);
    reset = 1'b1;
    #1;
    check("async_reset_rgb", 32'({red, green, blue}), 32'h0);
    tick();
    reset = 1'b0;
    pix(22, 4, 4'b0001);
    check("refill_rgb", 32'({red, green, blue}), 32'h0);
    pix(23, 4, 4'b0001);
    check("resume_rgb", 32'({red, green, blue}), 32'hF00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor for the VGA game path. It sits between the VGA timing controller and the DAC pins, and takes NUM_LAYERS sprite channels plus a horizontally scrolling tiled background from a 1-cycle-latency block RAM. It produces registered, sync-aligned RGB using fixed index priority with per-layer enable. It also adds per-frame scroll speed/pause and a per-frame collision report between layer 0 (player) and every other layer.

## Interface
Parameters:
- NUM_LAYERS, 4, sprite channels; index 0 is the player and has highest priority
- COLOR_W, 4, bits per colour component
- COL_W, 12, display_col width
- ROW_W, 11, display_row width
- SCROLL_W, 10, scroll offset width; the offset wraps modulo 2^SCROLL_W
- BG_SHIFT, 2, log2 of the background pixel size in screen pixels
- BG_COL_W, 8, background column index bits
- BG_ROW_W, 8, background row index bits

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- display_col  in  COL_W  current column from the timing controller
- display_row  in  ROW_W  current row from the timing controller
- visible  in  1  active-video flag
- hsync_in, vsync_in  in  1 each  raw syncs
- layer_visible  in  NUM_LAYERS  per-layer pixel-hit flags
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  channel i at [i*3*COLOR_W +: 3*COLOR_W]; packed {blue,green,red}, red in the LSBs
- layer_enable  in  NUM_LAYERS  layer mask; a disabled layer is ignored for both drawing and collision
- scroll_speed  in  SCROLL_W  pixels added to the offset per frame
- scroll_pause  in  1  freezes the offset
- bg_addr  out  BG_COL_W+BG_ROW_W  {col_idx,row_idx} to the background RAM
- bg_q  in  3*COLOR_W  RAM data, {blue,green,red}; valid 1 cycle after bg_addr
- red, green, blue  out  COLOR_W each  registered pixel colour
- hsync, vsync  out  1 each  syncs delayed to align with RGB
- collision_flags  out  NUM_LAYERS  bit i set if the player overlapped layer i during the last complete frame; bit 0 is always 0
- collision_valid  out  1  one-cycle pulse when collision_flags updates

## Operation
- Stage 0 (S0), combinational from inputs:
  - bg_x = (display_col + scroll_offset) truncated to COL_W bits
  - col_idx = bg_x[BG_SHIFT +: BG_COL_W]
  - row_idx = display_row[BG_SHIFT +: BG_ROW_W]
  - bg_addr is registered, so the RAM receives the address at S0 and bg_q is valid at S1.
- S0 also registers layer_visible, layer_rgb, layer_enable, visible, hsync_in, vsync_in, and a frame_start flag (display_col==0 && display_row==0) into S1.
- Scroll: when frame_start holds at S0 and scroll_pause=0, scroll_offset <= scroll_offset + scroll_speed, modulo 2^SCROLL_W. The new offset first applies to pixel (0,0) of the following frame; pixel (0,0) of the current frame uses the old offset.
- S1 mix, registered into the outputs:
  - If S1 visible=0, the output is RGB 0.
  - Otherwise the lowest index i with visible_s1[i] & enable_s1[i] supplies the colour.
  - If no layer qualifies, the output is bg_q: red=bg_q[COLOR_W-1:0], green next, blue top.
- Collision, at S1 with S1 visible=1: hit_i = visible_s1[0]&enable_s1[0]&visible_s1[i]&enable_s1[i] for i≥1. The accumulator acc[i] is ORed with hit_i.
- Frame boundary, when frame_start holds at S1:
  - collision_flags <= acc (excluding the current pixel)
  - acc <= hits of the current pixel
  - collision_valid=1 for that cycle
- Reset clears scroll_offset, acc, bg_addr, every pipeline register, RGB, hsync, vsync, collision_flags and collision_valid to 0. Reset mid-frame gives a black output until the pipeline refills. No collision_valid pulse occurs until the next frame_start reaches S1.

## Timing
- Latency is 2 clocks from the display_col/row/visible/sync inputs to the red/green/blue/hsync/vsync outputs. Sync and colour stay aligned exactly.
- Layer inputs must be valid in the same cycle as their display_col/row. The block delays them internally by 1 cycle to match bg_q.
- collision_valid asserts 2 cycles after (0,0) is presented, once per frame. No pulse occurs in the first partial frame after reset unless (0,0) arrives.
- Scroll wrap: with offset 1020 and speed 8 (SCROLL_W=10), the next offset is 4.
- Column addition overflow above COL_W bits is discarded.
- Changes to layer_enable take effect per pixel; no frame synchronisation is applied.

## Test plan
- Priority: layers 0 and 2 both visible, rgb0=0x00F, rgb2=0xF00, all enabled. Red=F, green=0, blue=0 two cycles later. With enable[0]=0, blue=F.
- Background path: no layers visible, scroll 0, col=8, row=4. bg_addr={8'd2,8'd1}. Drive bg_q=0xA53 one cycle later → red=3, green=5, blue=A.
- Blanking and sync: visible=0 with layers asserted → RGB 0. Toggle hsync_in → hsync follows 2 cycles later.
- Scroll: speed=8, pause=0, run 3 frames → offset 24. Set pause=1 for 2 frames → offset stays 24. Preload 1020 with speed 8 → offset 4.
- Collision: overlap player and layer 3 for one pixel in frame N → collision_flags=4'b1000 with a single collision_valid pulse at the start of frame N+1. A clean frame N+1 → flags=0 at frame N+2. Overlap on pixel (0,0) counts in the new frame.
- Reset mid-frame: assert reset while drawing → all outputs 0 immediately. Normal output resumes 2 cycles after release.
